// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage.
//   - default datapath / register-address widths
//   - ALU operation codes presented to the EX ALU
//   - ALU_OP encodings produced by the main decoder
//   - funct3 values recognised by the ALU control decoder
package id_ex_operand_stage_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned RA_W_DEF = 5;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLL     = 4'b1000,
    ALU_NOR     = 4'b1100,
    ALU_ILLEGAL = 4'b1111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/id_ex_operand_stage_alu_control_decode.sv
// ALU control decoder: maps the main decoder's ALU_OP class plus
// funct3/funct7[5] to the 4-bit operation code of the EX ALU.
// Ports:
//   alu_op    in  2  00 mem, 01 branch, 10 R-type, 11 I-type
//   funct3    in  3  instr[14:12]
//   funct7b5  in  1  instr[30]
//   operation out 4  ALU op code (ILLEGAL for unsupported encodings)
module alu_control_decode
  import id_ex_operand_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] operation
);

  always_comb begin
    operation = ALU_ILLEGAL;
    case (alu_op)
      ALUOP_MEM:    operation = ALU_ADD;
      ALUOP_BRANCH: operation = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          F3_ADD:  operation = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  operation = ALU_AND;
          F3_OR:   operation = ALU_OR;
          F3_SLL:  operation = ALU_SLL;
          default: operation = ALU_ILLEGAL;
        endcase
      end
      ALUOP_ITYPE: begin
        case (funct3)
          F3_ADD:  operation = ALU_ADD;
          F3_SLL:  operation = ALU_SLL;
          F3_AND:  operation = ALU_AND;
          F3_OR:   operation = ALU_OR;
          default: operation = ALU_ILLEGAL;
        endcase
      end
      default: operation = ALU_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 64-bit EX ALU.
// Captures decoded operands/control from ID (reset > flush > stall > load),
// forwards from EX/MEM and MEM/WB onto the A/B operand paths, presents the
// registered ALU operation code, and raises a load-use hazard request.
// Ports:
//   clk, reset, stall, flush          clock / sync active-high reset / hold / bubble
//   id_*                              decoded instruction from ID
//   exm_*, wb_*                       forwarding sources (EX/MEM, MEM/WB)
//   alu_a, alu_b, alu_operation       ALU inputs
//   ex_*                              registered fields passed down the pipe
//   load_use_hazard                   combinational stall request to hazard unit
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_alu_src,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_operation,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            load_use_hazard
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            alu_src;
    logic [3:0]      alu_operation;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
  } idex_t;

  // A bubble is an all-zero instruction; its operation code is the decode
  // of all-zero control (ADD) rather than a raw zero.
  localparam idex_t IDEX_BUBBLE = '{alu_operation: ALU_ADD, default: '0};

  idex_t      idex_d, idex_q;
  logic [3:0] id_operation;

  alu_control_decode u_alu_control_decode (
    .alu_op    (id_alu_op),
    .funct3    (id_funct3),
    .funct7b5  (id_funct7b5),
    .operation (id_operation)
  );

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = IDEX_BUBBLE;
    end else if (!stall) begin
      idex_d.valid         = id_valid;
      idex_d.pc            = id_pc;
      idex_d.rs1_data      = id_rs1_data;
      idex_d.rs2_data      = id_rs2_data;
      idex_d.imm           = id_imm;
      idex_d.rs1           = id_rs1;
      idex_d.rs2           = id_rs2;
      idex_d.rd            = id_rd;
      idex_d.alu_src       = id_alu_src;
      idex_d.alu_operation = id_operation;
      idex_d.reg_write     = id_reg_write;
      idex_d.mem_read      = id_mem_read;
      idex_d.mem_write     = id_mem_write;
      idex_d.mem_to_reg    = id_mem_to_reg;
      idex_d.branch        = id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= IDEX_BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  // EX/MEM has the younger result, so it is checked first; x0 never forwards.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            exm_we,
    input logic [RA_W-1:0] exm_dst,
    input logic [XLEN-1:0] exm_val,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_dst,
    input logic [XLEN-1:0] wb_val
  );
    if (exm_we && (exm_dst != '0) && (exm_dst == rs)) begin
      return exm_val;
    end else if (wb_we && (wb_dst != '0) && (wb_dst == rs)) begin
      return wb_val;
    end
    return rf_data;
  endfunction

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign fwd_rs1 = fwd(idex_q.rs1, idex_q.rs1_data, exm_reg_write, exm_rd, exm_result,
                       wb_reg_write, wb_rd, wb_result);
  assign fwd_rs2 = fwd(idex_q.rs2, idex_q.rs2_data, exm_reg_write, exm_rd, exm_result,
                       wb_reg_write, wb_rd, wb_result);

  assign alu_a         = fwd_rs1;
  assign alu_b         = idex_q.alu_src ? idex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_operation = idex_q.alu_operation;

  assign ex_valid      = idex_q.valid;
  assign ex_pc         = idex_q.pc;
  assign ex_imm        = idex_q.imm;
  assign ex_rd         = idex_q.rd;
  assign ex_reg_write  = idex_q.reg_write;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_mem_to_reg = idex_q.mem_to_reg;
  assign ex_branch     = idex_q.branch;

  assign load_use_hazard = id_valid && idex_q.valid && idex_q.mem_read &&
                           (idex_q.rd != '0) &&
                           ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic        id_valid;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [1:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic [63:0] exm_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [63:0] wb_result;
  logic [63:0] alu_a, alu_b, ex_pc, ex_imm, ex_store_data;
  logic [3:0]  alu_operation;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic        load_use_hazard;

  int checks = 0;
  int failures = 0;

  id_ex_operand_stage #(.XLEN(64), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
    .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_result(wb_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operation(alu_operation), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  logic        m_valid, m_src, m_rw, m_mr, m_mw, m_m2r, m_br;
  logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;

  // Operation table written straight from the decode rules.
  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7);
    if (op == 2'd0) return 4'b0010;
    if (op == 2'd1) return 4'b0110;
    if (op == 2'd2 && f3 == 3'b000) return f7 ? 4'b0110 : 4'b0010;
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b001) return 4'b1000;
    if (op == 2'd3 && f3 == 3'b000) return 4'b0010;
    return 4'b1111;
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [4:0] rs, input logic [63:0] rf);
    logic [63:0] v;
    v = rf;
    if (rs != 5'd0) begin
      if (wb_reg_write && wb_rd == rs) v = wb_result;
      if (exm_reg_write && exm_rd == rs) v = exm_result;
    end
    return v;
  endfunction

  task automatic model_edge();
    if (reset || flush) begin
      {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r, m_br} = '0;
      {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
      {m_rs1, m_rs2, m_rd} = '0;
      m_op = ref_op(2'b00, 3'b000, 1'b0);
    end else if (!stall) begin
      m_valid = id_valid;  m_pc = id_pc;  m_rs1d = id_rs1_data;  m_rs2d = id_rs2_data;
      m_imm = id_imm;  m_rs1 = id_rs1;  m_rs2 = id_rs2;  m_rd = id_rd;  m_src = id_alu_src;
      m_rw = id_reg_write;  m_mr = id_mem_read;  m_mw = id_mem_write;
      m_m2r = id_mem_to_reg;  m_br = id_branch;
      m_op = ref_op(id_alu_op, id_funct3, id_funct7b5);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string step);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] es;
    logic        eh;
    ea = ref_fwd(m_rs1, m_rs1d);
    es = ref_fwd(m_rs2, m_rs2d);
    eb = m_src ? m_imm : es;
    eh = id_valid && m_valid && m_mr && (m_rd != 5'd0) && (m_rd == id_rs1 || m_rd == id_rs2);
    chk({step, ".alu_a"}, alu_a, ea);
    chk({step, ".alu_b"}, alu_b, eb);
    chk({step, ".store"}, ex_store_data, es);
    chk({step, ".op"}, 64'(alu_operation), 64'(m_op));
    chk({step, ".valid"}, 64'(ex_valid), 64'(m_valid));
    chk({step, ".pc"}, ex_pc, m_pc);
    chk({step, ".imm"}, ex_imm, m_imm);
    chk({step, ".rd"}, 64'(ex_rd), 64'(m_rd));
    chk({step, ".ctl"},
        64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
        64'({m_rw, m_mr, m_mw, m_m2r, m_br}));
    chk({step, ".hazard"}, 64'(load_use_hazard), 64'(eh));
  endtask

  task automatic tick(input string step);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(step);
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_src = 0; id_alu_op = '0;
    id_funct3 = '0; id_funct7b5 = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
    exm_rd = '0; exm_reg_write = 0; exm_result = '0;
    wb_rd = '0; wb_reg_write = 0; wb_result = '0;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom_range(0, 1));
    id_pc = {$urandom(), $urandom()};
    id_rs1_data = {$urandom(), $urandom()};
    id_rs2_data = {$urandom(), $urandom()};
    id_imm = {$urandom(), $urandom()};
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_alu_src = 1'($urandom_range(0, 1));
    id_alu_op = 2'($urandom_range(0, 3));
    id_funct3 = 3'($urandom_range(0, 7));
    id_funct7b5 = 1'($urandom_range(0, 1));
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} =
      5'($urandom_range(0, 31));
  endtask

  task automatic rand_fw();
    exm_rd = 5'($urandom_range(0, 3));
    exm_reg_write = 1'($urandom_range(0, 1));
    exm_result = {$urandom(), $urandom()};
    wb_rd = 5'($urandom_range(0, 3));
    wb_reg_write = 1'($urandom_range(0, 1));
    wb_result = {$urandom(), $urandom()};
  endtask

  initial begin
    stall = 0; flush = 0; reset = 1;
    clear_id();
    // 1: reset with busy ID inputs, then add x3,x1,x2
    rand_id(); id_valid = 1; id_mem_read = 1; id_rd = 5'd1;
    tick("rst0");
    tick("rst1");
    chk("rst.alu_a", alu_a, 64'd0);
    chk("rst.op", 64'(alu_operation), 64'h2);
    chk("rst.valid", 64'(ex_valid), 64'd0);
    reset = 0;
    clear_id();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_rs1_data = 64'd5; id_rs2_data = 64'd7; id_alu_op = 2'b10; id_reg_write = 1;
    tick("add");
    chk("add.a", alu_a, 64'd5);
    chk("add.b", alu_b, 64'd7);
    chk("add.op", 64'(alu_operation), 64'h2);

    // 2: decode variants
    id_funct7b5 = 1;
    tick("sub");
    chk("sub.op", 64'(alu_operation), 64'h6);
    id_funct7b5 = 0; id_alu_op = 2'b11; id_funct3 = 3'b001; id_imm = 64'd4; id_alu_src = 1;
    tick("slli");
    chk("slli.op", 64'(alu_operation), 64'h8);
    chk("slli.b", alu_b, 64'd4);
    id_alu_op = 2'b10; id_funct3 = 3'b010; id_alu_src = 0;
    tick("rtype_f3_010");
    chk("illegal.op", 64'(alu_operation), 64'hF);
    id_funct3 = 3'b111;
    tick("and");
    chk("and.op", 64'(alu_operation), 64'h0);

    // 3: forwarding priority and x0
    clear_id();
    id_valid = 1; id_rs1 = 5'd1; id_rs1_data = 64'h11; id_alu_op = 2'b10;
    exm_rd = 5'd1; exm_reg_write = 1; exm_result = 64'hAA;
    wb_rd = 5'd1; wb_reg_write = 1; wb_result = 64'hBB;
    tick("fwd_both");
    chk("fwd.exm", alu_a, 64'hAA);
    exm_reg_write = 0;
    #1; check_outputs("fwd_wb");
    chk("fwd.wb", alu_a, 64'hBB);
    id_rs1 = 5'd0; id_rs1_data = 64'h33;
    exm_rd = 5'd0; exm_reg_write = 1; wb_rd = 5'd0;
    tick("fwd_x0");
    chk("fwd.x0", alu_a, 64'h33);

    // 4: stall holds, flush beats stall
    clear_id();
    id_valid = 1; id_pc = 64'h100; id_reg_write = 1; id_mem_write = 1;
    tick("pre_stall");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick("stall");
      chk("stall.pc", ex_pc, 64'h100);
    end
    flush = 1;
    tick("flush_stall");
    chk("flush.valid", 64'(ex_valid), 64'd0);
    chk("flush.rw", 64'(ex_reg_write), 64'd0);
    chk("flush.mw", 64'(ex_mem_write), 64'd0);
    flush = 0;
    // reset while stalled
    stall = 0; clear_id(); id_valid = 1; id_reg_write = 1;
    tick("pre_rst_stall");
    stall = 1; reset = 1;
    tick("rst_stall");
    chk("rst_stall.valid", 64'(ex_valid), 64'd0);
    stall = 0; reset = 0;

    // 5: load-use hazard
    clear_id();
    id_valid = 1; id_rd = 5'd5; id_mem_read = 1; id_reg_write = 1;
    tick("ld");
    id_mem_read = 0; id_rs1 = 5'd5; id_rs2 = 5'd1; id_rd = 5'd6; id_alu_op = 2'b10;
    #1; check_outputs("lu_hit");
    chk("lu.hit", 64'(load_use_hazard), 64'd1);
    id_valid = 0;
    #1; check_outputs("lu_idinv");
    chk("lu.idinv", 64'(load_use_hazard), 64'd0);
    id_valid = 1; id_rd = 5'd0; id_mem_read = 1; id_rs1 = 5'd0; id_rs2 = 5'd0;
    tick("ld_x0");
    #1; check_outputs("lu_x0");
    chk("lu.x0", 64'(load_use_hazard), 64'd0);

    // 6: store with immediate B and forwarded store data
    clear_id();
    id_valid = 1; id_alu_src = 1; id_imm = 64'd16; id_rs2 = 5'd4;
    id_rs2_data = 64'h99; id_mem_write = 1;
    wb_rd = 5'd4; wb_reg_write = 1; wb_result = 64'h1234;
    tick("store");
    chk("store.b", alu_b, 64'd16);
    chk("store.data", ex_store_data, 64'h1234);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      rand_id();
      rand_fw();
      tick("rand");
      rand_fw();
      #1; check_outputs("rand_fw");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
